eight_bit_serializer_module: RTL and testbench

Parallel-in, serial-out transmitter that sits directly upstream of the 8-bit shift register and drives its `shift_in` pin one bit per clock. It accepts a parallel word through a valid/ready handshake, emits it MSB-first with a framing `shift_valid` flag, and pulses `done` on the last bit. The block supports back-to-back words with no idle gap, so an 8-bit downstream shift register holds each complete word on the edge after every `done`.

---
 rtl/eight_bit_serializer_module_pkg.sv | 17 +
 rtl/eight_bit_serializer_module_if.sv | 30 +++
 rtl/eight_bit_serializer_module_bit_counter.sv | 39 +++
 rtl/eight_bit_serializer_module.sv | 79 +++++++
 tb/tb_eight_bit_serializer_module.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/eight_bit_serializer_module_pkg.sv
// Shared types and helpers for the parallel-in, serial-out transmitter.
// Holds the FSM state encoding, the default word length and the counter-width helper.
package eight_bit_serializer_module_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

  // At least one counter bit, even for degenerate widths.
  function automatic int unsigned cnt_width(int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/eight_bit_serializer_module_if.sv
// Upstream word handshake plus serial output bundle of the serializer.
// master = word producer / serial consumer side, slave = serializer side.
interface eight_bit_serializer_module_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] in;
  logic             in_valid;
  logic             in_ready;
  logic             shift_out;
  logic             shift_valid;
  logic             done;

  modport master (
    output in,
    output in_valid,
    input  in_ready,
    input  shift_out,
    input  shift_valid,
    input  done
  );

  modport slave (
    input  in,
    input  in_valid,
    output in_ready,
    output shift_out,
    output shift_valid,
    output done
  );
endinterface

// File: rtl/eight_bit_serializer_module_bit_counter.sv
// Synchronous mod-WIDTH up-counter tracking the bit position within a word.
// 'clear' wins over 'en'; 'last' flags the final bit position.
module bit_counter_module
  import eight_bit_serializer_module_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CntW  = cnt_width(WIDTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            en,
  output logic [CntW-1:0] count,
  output logic            last
);

  logic [CntW-1:0] count_q, count_d;

  assign last  = (count_q == CntW'(WIDTH - 1));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = last ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/eight_bit_serializer_module.sv
// Parallel-in, serial-out transmitter: accepts a word over valid/ready and shifts it out
// one bit per clock with a framing valid flag and a done pulse on the last bit.
module eight_bit_serializer_module
  import eight_bit_serializer_module_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic                          clk,
  input logic                          rst,
  eight_bit_serializer_module_if.slave bus
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CntW-1:0]  count;
  logic             last;
  logic             in_shift;
  logic             accept;
  logic             first_bit;
  logic             unused_count;

  assign in_shift = (state_q == StShift);

  // Ready depends only on state, counter and reset, never on in_valid.
  assign bus.in_ready = ~rst & (~in_shift | last);
  assign accept       = bus.in_valid & bus.in_ready;

  bit_counter_module #(
    .WIDTH (WIDTH),
    .CntW  (CntW)
  ) u_bit_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .en    (in_shift & ~last),
    .count (count),
    .last  (last)
  );

  assign unused_count = ^count;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (in_shift) begin
      data_d = MSB_FIRST ? (data_q << 1) : (data_q >> 1);
    end
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StShift;
      end
      StShift: begin
        if (last) state_d = accept ? StShift : StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A reload on the last bit overrides the shift for gapless back-to-back words.
    if (accept) data_d = bus.in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign first_bit       = MSB_FIRST ? data_q[WIDTH-1] : data_q[0];
  assign bus.shift_valid = in_shift;
  assign bus.shift_out   = in_shift & first_bit;
  assign bus.done        = in_shift & last;

endmodule

// File: tb/tb_eight_bit_serializer_module.sv
// Bench for the serializer: lane 0 is MSB-first, lane 1 is LSB-first.
// Each lane is tracked by a word/bits-remaining model derived from the timing rules.
module tb_eight_bit_serializer_module;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din  [2];
  logic       vval [2];
  int         rem  [2];
  logic [7:0] word [2];
  bit         accepted [2];
  logic [7:0] ds_q = 8'h00;
  int         compared   = 0;
  int         mismatched = 0;

  eight_bit_serializer_module_if #(.WIDTH(W)) bus0 ();
  eight_bit_serializer_module_if #(.WIDTH(W)) bus1 ();

  assign bus0.in       = din[0];
  assign bus0.in_valid = vval[0];
  assign bus1.in       = din[1];
  assign bus1.in_valid = vval[1];

  eight_bit_serializer_module #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  eight_bit_serializer_module #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  wire [1:0] rdy = {bus1.in_ready, bus0.in_ready};
  wire [1:0] so  = {bus1.shift_out, bus0.shift_out};
  wire [1:0] sv  = {bus1.shift_valid, bus0.shift_valid};
  wire [1:0] dn  = {bus1.done, bus0.done};

  always #5 clk = ~clk;

  // Downstream 8-bit shift register fed by the MSB-first lane.
  always @(posedge clk) ds_q <= {ds_q[6:0], bus0.shift_out};

  task automatic chk(input string tag, input int lane, input logic [7:0] obs,
                     input logic [7:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s lane%0d: observed %0h expected %0h", tag, lane, obs, exp);
    end
  endtask

  // One clock: check ready before the edge, advance the model, check outputs after it.
  task automatic tick();
    bit         acc [2];
    bit         chk_ds;
    logic [7:0] ds_word;
    int         idx;
    logic       exp_bit;
    #2;
    for (int l = 0; l < 2; l++) begin
      logic exp_rdy;
      exp_rdy = !rst && (rem[l] <= 1);
      chk("in_ready", l, {7'd0, rdy[l]}, {7'd0, exp_rdy});
      acc[l] = vval[l] && exp_rdy;
    end
    chk_ds  = !rst && (rem[0] == 1);
    ds_word = word[0];
    @(posedge clk);
    #1;
    for (int l = 0; l < 2; l++) begin
      accepted[l] = acc[l];
      if (rst) begin
        rem[l] = 0;
      end else begin
        if (rem[l] > 0) rem[l]--;
        if (acc[l]) begin
          word[l] = din[l];
          rem[l]  = W;
        end
      end
      idx     = W - rem[l];
      exp_bit = 1'b0;
      if (rem[l] > 0) exp_bit = (l == 0) ? word[l][W-1-idx] : word[l][idx];
      chk("shift_valid", l, {7'd0, sv[l]}, {7'd0, rem[l] > 0});
      chk("shift_out", l, {7'd0, so[l]}, {7'd0, exp_bit});
      chk("done", l, {7'd0, dn[l]}, {7'd0, rem[l] == 1});
    end
    if (chk_ds) chk("downstream", 0, ds_q, ds_word);
  endtask

  task automatic send(input int lane, input logic [7:0] w);
    int n;
    din[lane]  = w;
    vval[lane] = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!accepted[lane] && n < 20);
    chk("accept_within_budget", lane, {7'd0, accepted[lane]}, 8'd1);
    vval[lane] = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  initial begin
    for (int l = 0; l < 2; l++) begin
      din[l]  = 8'h00;
      vval[l] = 1'b0;
      rem[l]  = 0;
      word[l] = 8'h00;
    end

    // Reset hold with a word offered on both lanes.
    rst = 1'b1;
    din[0] = 8'hFF; din[1] = 8'hFF;
    vval[0] = 1'b1; vval[1] = 1'b1;
    drain(3);
    vval[0] = 1'b0; vval[1] = 1'b0;
    rst = 1'b0;
    drain(2);

    // Single word, then back-to-back pair with valid held.
    send(0, 8'b00010111);
    drain(2);
    send(0, 8'b10011110);
    send(0, 8'b10101100);
    drain(10);

    // Backpressure: new word offered at cycle 3 of the previous one.
    send(0, 8'($urandom));
    drain(2);
    send(0, 8'b01100001);
    drain(10);

    // Reset during bit 4, then a clean word.
    send(0, 8'b11101000);
    drain(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drain(2);
    send(0, 8'b10100011);
    drain(10);

    // LSB-first lane.
    send(1, 8'b10000011);
    drain(10);

    // Randomized traffic on both lanes with occasional resets.
    for (int c = 0; c < 300; c++) begin
      for (int l = 0; l < 2; l++) begin
        vval[l] = 1'($urandom_range(0, 1));
        din[l]  = 8'($urandom);
      end
      rst = ($urandom_range(0, 39) == 0);
      tick();
    end
    rst = 1'b0;
    vval[0] = 1'b0; vval[1] = 1'b0;
    drain(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
